// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Byte-stream program loader. It receives a word count, then
//               big-endian instruction words, then an XOR checksum. It writes
//               the words into program memory and holds the CPU in reset until
//               a load completes with a good checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // One extra count of headroom, so that N == MEMORY_DEPTH fits without wrapping
    localparam int c_idx_w = $clog2(MEMORY_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [7:0]           r_len;
    logic [c_idx_w-1:0]   r_word_idx;
    logic [1:0]           r_byte_cnt;
    logic [7:0]           r_csum;
    logic [23:0]          r_word;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;

    logic w_rx_ready;
    logic w_accept;
    logic w_len_bad;
    logic w_last_word;

    assign w_rx_ready  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept    = rx_valid && w_rx_ready;
    assign w_len_bad   = (rx_data == 8'd0) || (32'(rx_data) > 32'(MEMORY_DEPTH));
    assign w_last_word = ((32'(r_word_idx) + 32'd1) == 32'(r_len));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (w_accept) w_next_state = w_len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3)) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                w_next_state = w_last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_accept) w_next_state = (rx_data == r_csum) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) w_next_state = S_LEN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // The write address and data are captured on the fourth byte, so they are
    // stable through WRITE and hold their values afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len       <= 8'd0;
            r_word_idx  <= '0;
            r_byte_cnt  <= 2'd0;
            r_csum      <= 8'd0;
            r_word      <= 24'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_accept && !w_len_bad) begin
                        r_len      <= rx_data;
                        r_word_idx <= '0;
                        r_byte_cnt <= 2'd0;
                        r_csum     <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= {r_word[15:0], rx_data};
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr  <= BASE_ADDR + (32'(r_word_idx) << 2);
                            r_mem_wdata <= {r_word, rx_data};
                        end
                    end
                end
                S_WRITE: begin
                    r_word_idx <= r_word_idx + c_idx_w'(1);
                end
                default: ;
            endcase
        end
    end

    assign rx_ready  = w_rx_ready;
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = (r_state != S_DONE);
    assign busy      = (r_state == S_LEN) || (r_state == S_DATA) ||
                       (r_state == S_WRITE) || (r_state == S_CSUM);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader, using a byte-list
//               reference model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] obs_addr[$], obs_data[$];
    bit          exp_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
    end

    // Expected writes and final outcome, computed directly from the byte list
    task automatic model();
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'(stim[0]);
        if (n == 0 || n > DEPTH) begin
            exp_ok = 1'b0;
            return;
        end
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = {stim[1+4*i], stim[2+4*i], stim[3+4*i], stim[4+4*i]};
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w);
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        exp_ok = (stim[1+4*n] == x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit glitch);
        int t;
        for (int g = 0; g < gap; g++) begin
            start = glitch;
            @(negedge clk);
            if (mem_we) chk("write_ready", 32'(rx_ready), 32'd0);
            else        chk("gap_ready", 32'(rx_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("hs_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input int gap, input bit glitch);
        int m;
        obs_addr.delete();
        obs_data.delete();
        model();
        pulse_start();
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        foreach (stim[k]) send_byte(stim[k], gap, glitch);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            chk({tag, "_data"}, obs_data[i], exp_data[i]);
        end
        if (exp_addr.size() > 0) begin
            chk({tag, "_hold_addr"}, mem_addr, exp_addr[exp_addr.size()-1]);
            chk({tag, "_hold_data"}, mem_wdata, exp_data[exp_data.size()-1]);
        end
        chk({tag, "_done"},      32'(done),      32'(exp_ok));
        chk({tag, "_error"},     32'(error),     32'(!exp_ok));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_ok));
        chk({tag, "_busy_end"},  32'(busy),      32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_single(input logic [7:0] csum);
        stim = '{8'h01, 8'h20, 8'h08, 8'h00, 8'h05, csum};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] x;
        logic [7:0] b;

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready",  32'(rx_ready),  32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_error",     32'(error),     32'd0);
        reset = 1'b0;

        // rx_valid held in IDLE must not be accepted or change anything
        rx_valid = 1'b1; rx_data = 8'h01;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("idle_hold_busy",  32'(busy),            32'd0);
        chk("idle_hold_ready", 32'(rx_ready),        32'd0);
        chk("idle_hold_we",    32'(obs_addr.size()), 32'd0);
        rx_valid = 1'b0;

        set_single(8'h2D);
        run_load("single", 0, 1'b0);
        chk("single_addr_const", obs_addr[0], 32'h0040_0000);
        chk("single_data_const", obs_data[0], 32'h2008_0005);

        set_single(8'h2C);
        run_load("bad_csum", 0, 1'b0);

        set_single(8'h2D);
        run_load("stall", 5, 1'b0);

        stim = '{8'h00};
        run_load("len_zero", 0, 1'b0);
        stim = '{8'h21};
        run_load("len_over", 0, 1'b0);

        stim = '{8'h20};
        x = 8'd0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x = x ^ b;
        end
        stim.push_back(x);
        run_load("full", 0, 1'b0);
        chk("full_last_addr", obs_addr[obs_addr.size()-1], 32'h0040_007C);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            stim = '{8'(n)};
            x = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                stim.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(0, 1) == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
            stim.push_back(x);
            run_load("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset after the second data byte, then a complete reload
        set_single(8'h2D);
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        for (int k = 0; k < 3; k++) send_byte(stim[k], 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_rx_ready",  32'(rx_ready),  32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_mem_addr",  mem_addr,       32'd0);
        chk("midrst_mem_wdata", mem_wdata,      32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_no_write", 32'(obs_addr.size()), 32'd0);
        chk("midrst_idle",     32'(busy),            32'd0);
        run_load("reload", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
